// File: rtl/axis_irq_rsp_arb_pipe.sv
// axis_irq_rsp_arb_pipe: round-robin arbiter over NUM_CH IRQ response streams feeding an output FIFO.
// Optional macro AXIS_IRQ_RSP_ARB_STATS_EN adds saturating per-channel accept counters (ch_accept_cnt).
`ifndef IRQ_RSP_DW
`define IRQ_RSP_DW 32
`endif
module axis_irq_rsp_arb_pipe #(
    parameter int NUM_CH      = 4,
    parameter int TDATA_WIDTH = `IRQ_RSP_DW,
    parameter int DEPTH       = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                          s_if_clk,
    input  logic                          s_if_rst_n,
    input  logic [NUM_CH-1:0]             s_tvalid,
    input  logic [NUM_CH*TDATA_WIDTH-1:0] s_tdata,
    output logic [NUM_CH-1:0]             s_tready,
    output logic                          m_tvalid,
    output logic [TDATA_WIDTH-1:0]        m_tdata,
    output logic [CH_W-1:0]               m_tuser,
    input  logic                          m_tready,
`ifdef AXIS_IRQ_RSP_ARB_STATS_EN
    output logic [NUM_CH*16-1:0]          ch_accept_cnt,
`endif
    output logic [CNT_W-1:0]              occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int EW    = CH_W + TDATA_WIDTH;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d, gnt;
    logic             gnt_vld, full, push, pop;

    // Round-robin search: the smallest offset from rr_ptr wins, so offsets are scanned high to low
    always_comb begin
        gnt     = rr_ptr_q;
        gnt_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (s_tvalid[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                gnt     = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
                gnt_vld = 1'b1;
            end
        end
    end

    // Full blocks push even when a pop happens in the same cycle; reset gates both handshakes
    assign full      = cnt_q == CNT_W'(DEPTH);
    assign push      = s_if_rst_n && gnt_vld && !full;
    assign m_tvalid  = s_if_rst_n && (cnt_q != '0);
    assign pop       = m_tvalid && m_tready;
    assign s_tready  = push ? NUM_CH'(1) << gnt : '0;
    assign {m_tuser, m_tdata} = mem_q[rd_ptr_q];
    assign occupancy = cnt_q;

    // Next state of FIFO storage, pointers, occupancy and round-robin pointer
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {gnt, s_tdata[int'(gnt)*TDATA_WIDTH +: TDATA_WIDTH]};
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        rr_ptr_d = !push ? rr_ptr_q : (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
    end

    // State registers; storage needs no reset because the cleared pointers hide stale entries
    always_ff @(posedge s_if_clk) begin
        mem_q <= mem_d;
        if (!s_if_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef AXIS_IRQ_RSP_ARB_STATS_EN
    logic [15:0] acc_q [NUM_CH];
    logic [15:0] acc_d [NUM_CH];

    // Count accepted beats per source channel, saturating at all-ones
    always_comb begin
        acc_d = acc_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (push && int'(gnt) == c && acc_q[c] != 16'hFFFF) acc_d[c] = acc_q[c] + 16'd1;
        end
    end

    // Accept counter registers
    always_ff @(posedge s_if_clk) begin
        if (!s_if_rst_n) acc_q <= '{default: '0};
        else acc_q <= acc_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_acc
        assign ch_accept_cnt[g*16 +: 16] = acc_q[g];
    end
`endif
endmodule

// File: tb/tb_axis_irq_rsp_arb_pipe.sv
// tb_axis_irq_rsp_arb_pipe: directed scoreboard bench for the round-robin arbiter FIFO
module tb_axis_irq_rsp_arb_pipe;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   s_tvalid;
    logic [127:0] s_tdata;
    logic [3:0]   s_tready;
    logic         m_tvalid;
    logic [31:0]  m_tdata;
    logic [1:0]   m_tuser;
    logic         m_tready;
    logic [2:0]   occupancy;
`ifdef AXIS_IRQ_RSP_ARB_STATS_EN
    logic [63:0]  ch_accept_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [33:0] exp_q[$];

    axis_irq_rsp_arb_pipe #(.NUM_CH(4), .TDATA_WIDTH(32), .DEPTH(4)) dut (
        .s_if_clk(clk),
        .s_if_rst_n(rst_n),
        .s_tvalid(s_tvalid),
        .s_tdata(s_tdata),
        .s_tready(s_tready),
        .m_tvalid(m_tvalid),
        .m_tdata(m_tdata),
        .m_tuser(m_tuser),
        .m_tready(m_tready),
`ifdef AXIS_IRQ_RSP_ARB_STATS_EN
        .ch_accept_cnt(ch_accept_cnt),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(input int ch, input logic [31:0] v);
        s_tdata[ch*32 +: 32] = v;
    endtask

    task automatic expect_beat(input logic [1:0] ch, input logic [31:0] v);
        exp_q.push_back({ch, v});
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
        chk(name, exp_q.size(), 0);
    endtask

    // Monitor: every output handshake must match the oldest expected beat
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {m_tuser, m_tdata[29:0]}, 32'hDEAD_BEEF);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("beat_user", m_tuser, e[33:32]);
                chk("beat_data", m_tdata, e[31:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        s_tvalid = 4'hF;
        s_tdata = '0;
        m_tready = 1'b0;
        step(2);
        @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_occupancy", occupancy, 0);
        @(posedge clk);
        #1;
        // Test 1: all channels valid, sink always ready
        rst_n = 1'b1;
        m_tready = 1'b1;
        for (int c = 0; c < 4; c++) set_ch(c, 32'h10 + c);
        for (int i = 0; i < 8; i++) begin
            expect_beat(2'(i % 4), 32'h10 + (i % 4));
            @(negedge clk);
            chk("t1_s_tready", s_tready, 32'(1 << (i % 4)));
            chk("t1_occupancy", occupancy, i == 0 ? 0 : 1);
            chk("t1_m_tvalid", m_tvalid, i == 0 ? 0 : 1);
            @(posedge clk);
            #1;
        end
        s_tvalid = 4'h0;
        drain("t1_drain");
        // Test 2: channel 2 fills the FIFO while the sink stalls
        m_tready = 1'b0;
        s_tvalid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            set_ch(2, 32'hA0 + i);
            if (i < 4) expect_beat(2'd2, 32'hA0 + i);
            @(negedge clk);
            chk("t2_s_tready", s_tready, i < 4 ? 4'b0100 : 4'b0000);
            chk("t2_occupancy", occupancy, i);
            @(posedge clk);
            #1;
        end
        chk("t2_full", occupancy, 4);
        chk("t2_head_stall", m_tdata, 32'hA0);
        expect_beat(2'd2, 32'hA4);
        m_tready = 1'b1;
        @(negedge clk);
        chk("t2_pop_only_ready", s_tready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t2_push_after_pop", s_tready, 4'b0100);
        chk("t2_occ_after_pop", occupancy, 3);
        @(posedge clk);
        #1;
        s_tvalid = 4'h0;
        drain("t2_drain");
        // Test 3: full FIFO with pop and ch1 push offered together
        m_tready = 1'b0;
        s_tvalid = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            set_ch(1, 32'hB0 + i);
            expect_beat(2'd1, 32'hB0 + i);
            step();
        end
        set_ch(1, 32'hB4);
        expect_beat(2'd1, 32'hB4);
        m_tready = 1'b1;
        @(negedge clk);
        chk("t3_full_ready", s_tready, 0);
        chk("t3_full_occ", occupancy, 4);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t3_occ_drop", occupancy, 3);
        chk("t3_push_next", s_tready, 4'b0010);
        @(posedge clk);
        #1;
        s_tvalid = 4'h0;
        @(negedge clk);
        chk("t3_occ_pushpop", occupancy, 3);
        drain("t3_drain");
        // Test 4: steer rr_ptr to 3 with one ch2 beat, then channels 0 and 3 compete
        s_tvalid = 4'b0100;
        set_ch(2, 32'hC0);
        expect_beat(2'd2, 32'hC0);
        step();
        s_tvalid = 4'b1001;
        set_ch(0, 32'hD0);
        set_ch(3, 32'hD3);
        for (int i = 0; i < 3; i++) begin
            expect_beat(i == 1 ? 2'd0 : 2'd3, i == 1 ? 32'hD0 : 32'hD3);
            @(negedge clk);
            chk("t4_grant", s_tready, i == 1 ? 4'b0001 : 4'b1000);
            @(posedge clk);
            #1;
        end
        s_tvalid = 4'h0;
        drain("t4_drain");
        // Test 5: three beats parked (rr_ptr ends at 2), then reset discards them
        m_tready = 1'b0;
        s_tvalid = 4'b0110;
        set_ch(1, 32'hE1);
        set_ch(2, 32'hE2);
        step(3);
        s_tvalid = 4'h0;
        @(negedge clk);
        chk("t5_occ_before", occupancy, 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        s_tvalid = 4'b0101;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_rst_m_tvalid", m_tvalid, 0);
        chk("t5_rst_occ", occupancy, 0);
        chk("t5_rst_s_tready", s_tready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_tready = 1'b1;
        set_ch(0, 32'hF0);
        expect_beat(2'd0, 32'hF0);
        @(negedge clk);
        chk("t5_first_occ", occupancy, 0);
        chk("t5_first_grant", s_tready, 4'b0001);
        @(posedge clk);
        #1;
        s_tvalid = 4'h0;
        drain("t5_drain");
`ifdef AXIS_IRQ_RSP_ARB_STATS_EN
        // Test 6: counter saturation on channel 1 after a clean reset
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        m_tready = 1'b1;
        s_tvalid = 4'b0010;
        set_ch(1, 32'h66);
        for (int i = 0; i < 70000; i++) begin
            expect_beat(2'd1, 32'h66);
            step();
        end
        s_tvalid = 4'h0;
        drain("t6_drain");
        chk("t6_cnt1", ch_accept_cnt[31:16], 16'hFFFF);
        chk("t6_cnt0", ch_accept_cnt[15:0], 0);
        chk("t6_cnt2", ch_accept_cnt[47:32], 0);
        chk("t6_cnt3", ch_accept_cnt[63:48], 0);
`endif
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
